// File: rtl/sbus_pkg.sv
// Shared constants for the SPI responder: register map, bit positions, FSM states.
package sbus_pkg;
  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_DIV    = 8'h01;
  localparam logic [7:0] ADDR_TXDATA = 8'h02;
  localparam logic [7:0] ADDR_RXDATA = 8'h03;
  localparam logic [7:0] ADDR_STATUS = 8'h04;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_CS_MAN = 1;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_RXV    = 1;
  localparam int STAT_OVR    = 2;

  localparam logic [7:0] DIV_RST = 8'h0D;

  typedef enum logic [1:0] {ST_IDLE, ST_LEAD, ST_HIGH, ST_LOW} spi_state_e;
endpackage

// File: rtl/sbus_spi_responder_if.sv
// 8-bit system bus between the initiator (master) and a register responder (slave).
interface sbus_spi_responder_if;
  logic       stb;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ack;

  modport master (output stb, rw, addr, wdata, input rdata, ack);
  modport slave  (input stb, rw, addr, wdata, output rdata, ack);
endinterface

// File: rtl/spi_shift_engine.sv
// Mode-0 MSB-first 8-bit SPI shifter; every phase lasts div+1 cycles, div latched at start.
// done pulses on the last LOW cycle so the caller can capture rxbyte on the same edge busy falls.
module spi_shift_engine
  import sbus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] txbyte,
  input  logic [7:0] div,
  input  logic       cs_man,
  input  logic       spi_miso,
  output logic       busy,
  output logic       done,
  output logic [7:0] rxbyte,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n
);
  spi_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] div_q, div_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_q, bit_d;
  logic       miso_q, miso_d;
  logic       phase_end;
  logic       sample;

  assign phase_end = (cnt_q == div_q);
  // With a one-cycle phase the captured bit is not registered yet, so take it live.
  assign sample    = (cnt_q == 8'd0) ? spi_miso : miso_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = phase_end ? 8'd0 : cnt_q + 8'd1;
    div_d   = div_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    miso_d  = miso_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        if (start) begin
          state_d = ST_LEAD;
          div_d   = div;
          sr_d    = txbyte;
          bit_d   = 3'd0;
        end
      end
      ST_LEAD: if (phase_end) state_d = ST_HIGH;
      ST_HIGH: begin
        if (cnt_q == 8'd0) miso_d = spi_miso;
        if (phase_end) begin
          state_d = ST_LOW;
          sr_d    = {sr_q[6:0], sample};
        end
      end
      ST_LOW: begin
        if (phase_end) begin
          if (bit_q == 3'd7) begin
            state_d = ST_IDLE;
            done    = 1'b1;
          end else begin
            state_d = ST_HIGH;
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      div_q   <= 8'd0;
      sr_q    <= 8'd0;
      bit_q   <= 3'd0;
      miso_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      miso_q  <= miso_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign rxbyte   = sr_q;
  assign spi_sclk = (state_q == ST_HIGH);
  assign spi_mosi = busy ? sr_q[7] : 1'b0;
  assign spi_cs_n = ~(busy | cs_man);
endmodule

// File: rtl/sbus_spi_responder.sv
// Bus-side register file and one-cycle ack for the SPI master; read data registered with ack.
// A held strobe yields one access every two cycles because ack masks the following cycle.
module sbus_spi_responder #(
  parameter logic [7:0] DIV_RST = sbus_pkg::DIV_RST
) (
  input  logic                 clk,
  input  logic                 rst,
  sbus_spi_responder_if.slave  bus,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  output logic                 spi_cs_n,
  input  logic                 spi_miso,
  output logic                 busy
);
  import sbus_pkg::*;

  logic       ack_q, ack_d;
  logic [7:0] rdata_q, rdata_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic [7:0] div_q, div_d;
  logic [7:0] rxdata_q, rxdata_d;
  logic       rxv_q, rxv_d;
  logic       ovr_q, ovr_d;

  logic       access, wr, rd, tx_wr, start;
  logic       eng_busy, eng_done;
  logic [7:0] eng_rxbyte;
  logic [7:0] status;

  assign access = bus.stb & ~ack_q;
  assign wr     = access & bus.rw;
  assign rd     = access & ~bus.rw;
  assign tx_wr  = wr & (bus.addr == ADDR_TXDATA);
  assign start  = tx_wr & ctrl_q[CTRL_EN] & ~eng_busy;

  always_comb begin
    status            = 8'h00;
    status[STAT_BUSY] = eng_busy;
    status[STAT_RXV]  = rxv_q;
    status[STAT_OVR]  = ovr_q;
  end

  always_comb begin
    ack_d    = access;
    rdata_d  = 8'h00;
    ctrl_d   = ctrl_q;
    div_d    = div_q;
    rxdata_d = rxdata_q;
    rxv_d    = rxv_q;
    ovr_d    = ovr_q;
    if (wr) begin
      case (bus.addr)
        ADDR_CTRL:   ctrl_d = bus.wdata[1:0];
        ADDR_DIV:    div_d  = bus.wdata;
        ADDR_STATUS: if (bus.wdata[STAT_OVR]) ovr_d = 1'b0;
        default: ;
      endcase
    end
    if (rd) begin
      case (bus.addr)
        ADDR_CTRL:   rdata_d = {6'd0, ctrl_q};
        ADDR_DIV:    rdata_d = div_q;
        ADDR_RXDATA: begin
          rdata_d = rxdata_q;
          rxv_d   = 1'b0;
        end
        ADDR_STATUS: rdata_d = status;
        default: ;
      endcase
    end
    // Later assignments win: overrun beats W1C, completion beats the RXDATA read-clear.
    if (tx_wr && eng_busy) ovr_d = 1'b1;
    if (eng_done) begin
      rxdata_d = eng_rxbyte;
      rxv_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= 1'b0;
      rdata_q  <= 8'h00;
      ctrl_q   <= 2'b00;
      div_q    <= DIV_RST;
      rxdata_q <= 8'h00;
      rxv_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      ctrl_q   <= ctrl_d;
      div_q    <= div_d;
      rxdata_q <= rxdata_d;
      rxv_q    <= rxv_d;
      ovr_q    <= ovr_d;
    end
  end

  spi_shift_engine u_engine (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .txbyte   (bus.wdata),
    .div      (div_q),
    .cs_man   (ctrl_q[CTRL_CS_MAN]),
    .spi_miso (spi_miso),
    .busy     (eng_busy),
    .done     (eng_done),
    .rxbyte   (eng_rxbyte),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_cs_n (spi_cs_n)
  );

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign busy      = eng_busy;
endmodule
